// File: rtl/sat_sweep_ctrl.sv
// sat_sweep_ctrl: steps the GPS core through a satellite range, loading phase and dwelling per satellite.
// Optional SYNC timeout with sticky err_out is enabled by defining SWEEP_TIMEOUT_EN.
module sat_sweep_ctrl #(
  parameter int SYNC_TIMEOUT = 65535,
  parameter int DWELL_W      = 10
) (
  input  logic               clk_in,
  input  logic               rst_in_n,
  input  logic               sweep_en_in,
  input  logic               loop_in,
  input  logic [4:0]         first_sat_in,
  input  logic [4:0]         last_sat_in,
  input  logic [DWELL_W-1:0] dwell_in,
  input  logic [15:0]        ca_phase_base_in,
  input  logic [15:0]        ca_phase_step_in,
  input  logic               code_phase_done_in,
  input  logic               epoch_in,
  output logic               core_ena_out,
  output logic [4:0]         n_sat_out,
  output logic               ca_phase_start_out,
  output logic [15:0]        ca_phase_out,
  output logic               busy_out,
  output logic               sweep_done_out,
  output logic               err_out
);
  typedef enum logic [2:0] {IDLE, LOAD, SYNC, DWELL, NEXT, DONE} state_t;
  state_t state, nxt;
  logic [4:0] first_s, last_s, sat_nxt;
  logic [15:0] base_s, step_s, phase_nxt;
  logic [DWELL_W-1:0] dwell_s, dwell_max, cnt, cnt_nxt;
  logic start, reload, adv, timeout;
  assign dwell_max = (dwell_s == '0) ? DWELL_W'(1) : dwell_s;
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) state <= IDLE;
    else state <= nxt;
  // abort (sweep_en low) overrides every other transition
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = sweep_en_in ? LOAD : IDLE;
      LOAD:    nxt = SYNC;
      SYNC:    nxt = code_phase_done_in ? DWELL : (timeout ? NEXT : SYNC);
      DWELL:   nxt = (epoch_in && cnt + 1'b1 == dwell_max) ? NEXT : DWELL;
      NEXT:    nxt = (n_sat_out == last_s) ? DONE : LOAD;
      DONE:    nxt = loop_in ? LOAD : IDLE;
      default: nxt = IDLE;
    endcase
    if (!sweep_en_in) nxt = IDLE;
  end
  always_comb begin
    start     = state == IDLE && nxt == LOAD;
    reload    = state == DONE && nxt == LOAD;
    adv       = state == NEXT && nxt == LOAD;
    sat_nxt   = start ? first_sat_in : reload ? first_s : adv ? n_sat_out + 5'd1 : n_sat_out;
    phase_nxt = start ? ca_phase_base_in : reload ? base_s : adv ? ca_phase_out + step_s : ca_phase_out;
    cnt_nxt   = (state == DWELL && nxt == DWELL) ? cnt + DWELL_W'(epoch_in) : '0;
  end
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      core_ena_out       <= 1'b0;
      busy_out           <= 1'b0;
      ca_phase_start_out <= 1'b0;
      sweep_done_out     <= 1'b0;
      n_sat_out          <= '0;
      ca_phase_out       <= '0;
      cnt                <= '0;
      first_s            <= '0;
      last_s             <= '0;
      dwell_s            <= '0;
      base_s             <= '0;
      step_s             <= '0;
    end else begin
      core_ena_out       <= nxt != IDLE;
      busy_out           <= nxt != IDLE;
      ca_phase_start_out <= nxt == LOAD;
      sweep_done_out     <= nxt == DONE;
      n_sat_out          <= sat_nxt;
      ca_phase_out       <= phase_nxt;
      cnt                <= cnt_nxt;
      if (start) begin
        first_s <= first_sat_in;
        last_s  <= last_sat_in;
        dwell_s <= dwell_in;
        base_s  <= ca_phase_base_in;
        step_s  <= ca_phase_step_in;
      end
    end
`ifdef SWEEP_TIMEOUT_EN
  localparam int TW = $clog2(SYNC_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign timeout = state == SYNC && !code_phase_done_in && tcnt == TW'(SYNC_TIMEOUT - 1);
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      tcnt    <= '0;
      err_out <= 1'b0;
    end else begin
      tcnt    <= (state == SYNC && nxt == SYNC) ? tcnt + 1'b1 : '0;
      err_out <= start ? 1'b0 : (err_out | (timeout && nxt == NEXT));
    end
`else
  assign timeout = SYNC_TIMEOUT < 0;
  assign err_out = 1'b0;
`endif
endmodule

// File: tb/tb_sat_sweep_ctrl.sv
// tb_sat_sweep_ctrl: randomized self-checking bench for sat_sweep_ctrl against an arithmetic sweep model.
module tb_sat_sweep_ctrl;
  logic clk_in = 0, rst_in_n = 0;
  logic sweep_en_in = 0, loop_in = 0, code_phase_done_in = 0, epoch_in = 0;
  logic [4:0] first_sat_in = 0, last_sat_in = 0;
  logic [9:0] dwell_in = 0;
  logic [15:0] ca_phase_base_in = 0, ca_phase_step_in = 0;
  logic core_ena_out, ca_phase_start_out, busy_out, sweep_done_out, err_out;
  logic [4:0] n_sat_out;
  logic [15:0] ca_phase_out;
  int checks = 0, passed = 0, dones = 0;

  sat_sweep_ctrl #(.SYNC_TIMEOUT(20), .DWELL_W(10)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .sweep_en_in(sweep_en_in), .loop_in(loop_in),
    .first_sat_in(first_sat_in), .last_sat_in(last_sat_in), .dwell_in(dwell_in),
    .ca_phase_base_in(ca_phase_base_in), .ca_phase_step_in(ca_phase_step_in),
    .code_phase_done_in(code_phase_done_in), .epoch_in(epoch_in),
    .core_ena_out(core_ena_out), .n_sat_out(n_sat_out), .ca_phase_start_out(ca_phase_start_out),
    .ca_phase_out(ca_phase_out), .busy_out(busy_out), .sweep_done_out(sweep_done_out), .err_out(err_out));

  always #5 clk_in = ~clk_in;
  always @(negedge clk_in) if (sweep_done_out) dones++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // expected visit k: sat = first+k mod 32, phase = base + k*step mod 2^16
  task automatic run_pass(input string nm, input logic [4:0] f, input logic [4:0] l, input logic [9:0] dw,
                          input logic [15:0] b, input logic [15:0] s, input int passes);
    int n, de, d0;
    logic [4:0] es;
    logic [15:0] ep;
    n = int'(5'(l - f)) + 1;
    de = (dw == 0) ? 1 : int'(dw);
    d0 = dones;
    first_sat_in = f; last_sat_in = l; dwell_in = dw;
    ca_phase_base_in = b; ca_phase_step_in = s;
    loop_in = passes > 1;
    sweep_en_in = 1;
    cyc();
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < n; k++) begin
        es = f + 5'(k);
        ep = b + 16'(k) * s;
        checks++;
        if ({ca_phase_start_out, core_ena_out, busy_out, n_sat_out, ca_phase_out} !== {3'b111, es, ep})
          $display("FAIL %s load p%0d k%0d: got strb/ena/busy=%b%b%b sat=%0d ph=%h, want 111 sat=%0d ph=%h",
                   nm, p, k, ca_phase_start_out, core_ena_out, busy_out, n_sat_out, ca_phase_out, es, ep);
        else passed++;
        first_sat_in = 5'($urandom); last_sat_in = 5'($urandom); dwell_in = 10'($urandom);
        ca_phase_base_in = 16'($urandom); ca_phase_step_in = 16'($urandom);
        code_phase_done_in = 1'($urandom); epoch_in = 1'($urandom);
        cyc();
        repeat ($urandom_range(0, 4)) begin
          code_phase_done_in = 0; epoch_in = 1'($urandom);
          cyc();
        end
        code_phase_done_in = 1; epoch_in = 1'($urandom);
        cyc();
        code_phase_done_in = 0; epoch_in = 0;
        checks++;
        if ({ca_phase_start_out, core_ena_out, busy_out, sweep_done_out} !== 4'b0110)
          $display("FAIL %s dwell p%0d k%0d: got strb/ena/busy/done=%b%b%b%b want 0110",
                   nm, p, k, ca_phase_start_out, core_ena_out, busy_out, sweep_done_out);
        else passed++;
        for (int e = 0; e < de; e++) begin
          repeat ($urandom_range(0, 3)) cyc();
          epoch_in = 1;
          cyc();
          epoch_in = 0;
        end
        cyc();
      end
      checks++;
      if ({sweep_done_out, busy_out, core_ena_out, ca_phase_start_out} !== 4'b1110)
        $display("FAIL %s done p%0d: got done/busy/ena/strb=%b%b%b%b want 1110",
                 nm, p, sweep_done_out, busy_out, core_ena_out, ca_phase_start_out);
      else passed++;
      if (p == passes - 1) sweep_en_in = 0;
      cyc();
    end
    checks++;
    if ({busy_out, core_ena_out, sweep_done_out, ca_phase_start_out} !== 4'b0000)
      $display("FAIL %s idle: got busy/ena/done/strb=%b%b%b%b want 0000",
               nm, busy_out, core_ena_out, sweep_done_out, ca_phase_start_out);
    else passed++;
    checks++;
    if (dones - d0 !== passes) $display("FAIL %s done_count: got %0d want %0d", nm, dones - d0, passes);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if ({core_ena_out, n_sat_out, ca_phase_start_out, ca_phase_out, busy_out, sweep_done_out, err_out} !== '0)
      $display("FAIL reset_hold: got ena=%b sat=%0d ph=%h busy=%b want all 0", core_ena_out, n_sat_out, ca_phase_out, busy_out);
    else passed++;
    rst_in_n = 1;
    cyc();
    checks++;
    if ({core_ena_out, ca_phase_start_out, busy_out, sweep_done_out, err_out} !== '0)
      $display("FAIL reset_idle: got ena/strb/busy/done/err=%b%b%b%b%b want 00000",
               core_ena_out, ca_phase_start_out, busy_out, sweep_done_out, err_out);
    else passed++;
  endtask

  task automatic test_random();
    logic [4:0] f;
    for (int i = 0; i < 4; i++) begin
      f = 5'($urandom);
      run_pass("random", f, f + 5'($urandom_range(0, 7)), 10'($urandom_range(0, 3)),
               16'($urandom), 16'($urandom), $urandom_range(1, 2));
    end
  endtask

  task automatic test_abort();
    int d0;
    first_sat_in = 9; last_sat_in = 12; dwell_in = 4;
    ca_phase_base_in = 16'h2222; ca_phase_step_in = 16'h0101; loop_in = 0;
    sweep_en_in = 1;
    cyc();
    d0 = dones;
    cyc();
    code_phase_done_in = 1;
    cyc();
    code_phase_done_in = 0; epoch_in = 1;
    cyc();
    epoch_in = 0;
    cyc();
    sweep_en_in = 0;
    cyc();
    checks++;
    if ({core_ena_out, busy_out, ca_phase_start_out, sweep_done_out} !== 4'b0000)
      $display("FAIL abort_edge: got ena/busy/strb/done=%b%b%b%b want 0000",
               core_ena_out, busy_out, ca_phase_start_out, sweep_done_out);
    else passed++;
    repeat (3) cyc();
    checks++;
    if (dones !== d0) $display("FAIL abort_no_done: got %0d done pulses want 0", dones - d0);
    else passed++;
    sweep_en_in = 1;
    cyc();
    checks++;
    if ({ca_phase_start_out, busy_out, n_sat_out, ca_phase_out} !== {2'b11, 5'd9, 16'h2222})
      $display("FAIL abort_restart: got strb/busy=%b%b sat=%0d ph=%h want 11 sat=9 ph=2222",
               ca_phase_start_out, busy_out, n_sat_out, ca_phase_out);
    else passed++;
    sweep_en_in = 0;
    cyc();
  endtask

`ifdef SWEEP_TIMEOUT_EN
  task automatic test_timeout();
    first_sat_in = 2; last_sat_in = 3; dwell_in = 1;
    ca_phase_base_in = 16'h1000; ca_phase_step_in = 16'h0100; loop_in = 0;
    sweep_en_in = 1;
    cyc();
    cyc();
    repeat (19) cyc();
    checks++;
    if ({err_out, core_ena_out, ca_phase_start_out} !== 3'b010)
      $display("FAIL timeout_pre: got err/ena/strb=%b%b%b want 010", err_out, core_ena_out, ca_phase_start_out);
    else passed++;
    cyc();
    checks++;
    if (err_out !== 1'b1) $display("FAIL timeout_err: got %b want 1", err_out);
    else passed++;
    cyc();
    checks++;
    if ({err_out, ca_phase_start_out, n_sat_out, ca_phase_out} !== {2'b11, 5'd3, 16'h1100})
      $display("FAIL timeout_next: got err/strb=%b%b sat=%0d ph=%h want 11 sat=3 ph=1100",
               err_out, ca_phase_start_out, n_sat_out, ca_phase_out);
    else passed++;
    sweep_en_in = 0;
    cyc();
    checks++;
    if ({err_out, busy_out} !== 2'b10) $display("FAIL timeout_sticky: got err/busy=%b%b want 10", err_out, busy_out);
    else passed++;
    sweep_en_in = 1;
    cyc();
    checks++;
    if ({err_out, ca_phase_start_out} !== 2'b01) $display("FAIL timeout_clear: got err/strb=%b%b want 01", err_out, ca_phase_start_out);
    else passed++;
    sweep_en_in = 0;
    cyc();
  endtask
`else
  task automatic test_timeout();
    first_sat_in = 2; last_sat_in = 3; dwell_in = 1; loop_in = 0;
    sweep_en_in = 1;
    cyc();
    repeat (30) cyc();
    checks++;
    if ({err_out, core_ena_out, ca_phase_start_out, busy_out} !== 4'b0101)
      $display("FAIL no_timeout: got err/ena/strb/busy=%b%b%b%b want 0101",
               err_out, core_ena_out, ca_phase_start_out, busy_out);
    else passed++;
    sweep_en_in = 0;
    cyc();
  endtask
`endif

  task automatic test_async_reset();
    first_sat_in = 17; last_sat_in = 20; dwell_in = 2;
    ca_phase_base_in = 16'hABCD; ca_phase_step_in = 16'h0003; loop_in = 1;
    sweep_en_in = 1;
    cyc();
    cyc();
    #2 rst_in_n = 0;
    #1;
    checks++;
    if ({core_ena_out, n_sat_out, ca_phase_start_out, ca_phase_out, busy_out, sweep_done_out, err_out} !== '0)
      $display("FAIL async_reset: got ena=%b sat=%0d ph=%h busy=%b want all 0", core_ena_out, n_sat_out, ca_phase_out, busy_out);
    else passed++;
    sweep_en_in = 0;
    #2 rst_in_n = 1;
    cyc();
    checks++;
    if ({core_ena_out, busy_out, ca_phase_start_out} !== 3'b000)
      $display("FAIL async_reset_idle: got ena/busy/strb=%b%b%b want 000", core_ena_out, busy_out, ca_phase_start_out);
    else passed++;
  endtask

  initial begin
    test_reset();
    run_pass("basic", 5'd3, 5'd5, 10'd2, 16'h0100, 16'h0010, 1);
    run_pass("wrap", 5'd30, 5'd1, 10'd1, 16'h8000, 16'hC000, 1);
    run_pass("dwell0_loop", 5'd7, 5'd7, 10'd0, 16'h0F00, 16'h1234, 3);
    test_random();
    test_abort();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sat_sweep_ctrl.md
Name: sat_sweep_ctrl

Overview:
- Sequences the GPS generator core through a range of satellite indices (PRN slots 0..31).
- For each satellite it:
  - loads the satellite index and a code phase,
  - pulses the core's code-phase load,
  - waits for the core to report the phase reached,
  - keeps the core enabled for a programmed number of code epochs,
  - then advances to the next satellite.
- Sits between the UART register bank and the core's n_sat/ca_phase/enable inputs. It replaces static register-bank control when a sweep is requested.

Parameters:
- SYNC_TIMEOUT, 65535, clock cycles allowed in SYNC before giving up on code_phase_done (used only with SWEEP_TIMEOUT_EN).
- DWELL_W, 10, width of the dwell (epochs-per-satellite) count.

Ports:
- clk_in  input  1  system clock.
- rst_in_n  input  1  asynchronous active-low reset.
- sweep_en_in  input  1  level; high = run/keep running the sweep, low = abort/idle.
- loop_in  input  1  1 = restart at first_sat after last_sat, 0 = single pass.
- first_sat_in  input  5  first satellite index.
- last_sat_in  input  5  last satellite index.
- dwell_in  input  DWELL_W  code epochs per satellite; 0 is treated as 1.
- ca_phase_base_in  input  16  code phase for the first satellite.
- ca_phase_step_in  input  16  phase increment added for each successive satellite.
- code_phase_done_in  input  1  core reports the loaded phase has been reached.
- epoch_in  input  1  one-cycle pulse per code epoch from the core (start_out).
- core_ena_out  output  1  core enable.
- n_sat_out  output  5  satellite index to the core.
- ca_phase_start_out  output  1  one-cycle code-phase load strobe.
- ca_phase_out  output  16  code phase to the core.
- busy_out  output  1  sweep in progress.
- sweep_done_out  output  1  one-cycle pulse at the end of each pass.
- err_out  output  1  sticky; a SYNC timeout occurred.

Behaviour:
- Clocking and reset: one clock, clk_in. Reset is asynchronous, active-low, on rst_in_n.
- All outputs are registered. On reset every output is 0 and state = IDLE.
- States: IDLE, LOAD, SYNC, DWELL, NEXT, DONE.
- IDLE:
  - core_ena_out=0, busy_out=0.
  - When sweep_en_in=1 is sampled, latch first/last/dwell/base/step into shadow registers and go to LOAD.
  - Inputs changing during a sweep have no effect until the next IDLE→LOAD.
- LOAD (1 cycle):
  - ca_phase_start_out=1, core_ena_out=1, busy_out=1.
  - n_sat_out and ca_phase_out hold the current values; on the first entry these are first_sat and base.
  - Next state: SYNC.
- Latency: the cycle after sweep_en_in is sampled high in IDLE, all of the following are true: ca_phase_start_out=1, core_ena_out=1, busy_out=1, n_sat_out=first_sat, ca_phase_out=base.
- SYNC:
  - Wait for code_phase_done_in=1, then go to DWELL and clear the epoch counter.
  - code_phase_done_in high in the LOAD cycle is ignored; only SYNC samples it.
- DWELL:
  - Count epoch_in pulses.
  - On the epoch_in pulse that makes the count equal max(dwell,1), go to NEXT.
- NEXT (1 cycle; core_ena_out stays 1):
  - If n_sat == last_sat, go to DONE.
  - Otherwise: n_sat ← n_sat+1 mod 32, ca_phase ← ca_phase+step mod 2^16, go to LOAD.
- Wrap-around range: if first_sat > last_sat, the sweep runs first..31, 0..last.
- Single satellite: first_sat == last_sat gives a one-satellite pass.
- DONE (1 cycle): sweep_done_out=1.
  - If loop_in=1 and sweep_en_in=1: reload n_sat=first, ca_phase=base, go to LOAD. busy_out stays 1.
  - Else: go to IDLE; core_ena_out=0 and busy_out=0 from the following cycle.
- Abort: sweep_en_in=0 sampled in any non-IDLE state forces IDLE on the next edge.
  - core_ena_out=0 and busy_out=0 on that edge.
  - No sweep_done_out pulse.
  - Counters are cleared.
- Simultaneous events:
  - Abort has priority over every other transition.
  - epoch_in in the SYNC→DWELL cycle is not counted.
- err_out is cleared only by reset or by an IDLE→LOAD start.

Optional Feature:
- Macro: SWEEP_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in SYNC.
  - After SYNC_TIMEOUT cycles without code_phase_done_in: set err_out=1 and go to NEXT, skipping DWELL for that satellite.
- Undefined:
  - SYNC waits indefinitely.
  - err_out is tied to 0; the port remains present.

Test Plan:
- Basic pass: first=3, last=5, dwell=2, base=0x0100, step=0x0010, code_phase_done 4 cycles after each strobe.
  - Expect 3 ca_phase_start pulses with (n_sat, ca_phase) = (3,0x0100), (4,0x0110), (5,0x0120).
  - Expect 2 epochs per satellite, one sweep_done pulse, then core_ena=0 and busy=0.
- Wrap range with phase overflow: first=30, last=1, step=0xC000, base=0x8000.
  - Expect n_sat sequence 30, 31, 0, 1.
  - Expect phases 0x8000, 0x4000, 0x0000, 0xC000.
- Dwell zero and loop: dwell=0, first=last=7, loop=1.
  - Expect one epoch per visit.
  - Expect repeated LOAD for satellite 7 with a sweep_done pulse each pass.
  - Deassert sweep_en → IDLE next edge.
- Abort mid-DWELL: drop sweep_en after 1 of 4 epochs.
  - Expect core_ena=0 and busy=0 on the next edge, no sweep_done pulse.
  - Re-enable → restart at first_sat.
- Timeout (SWEEP_TIMEOUT_EN, SYNC_TIMEOUT=20): never assert code_phase_done.
  - Expect err_out=1 after 20 SYNC cycles and advance to the next satellite.
  - err_out clears on the next start.
- Async reset asserted mid-SYNC: all outputs 0 immediately, without waiting for a clock edge; state = IDLE.
